// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
//   Shared types and constants for the multicycle RV32I control FSM:
//   state and instruction-class enums, base opcodes, branch funct3 codes,
//   and the DECODE-stage opcode classifier.
package core_ctrl_pkg;

    typedef logic [6:0] opcode_t;
    typedef logic [2:0] funct3_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        C_R,
        C_IMM,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC
    } class_t;

    localparam opcode_t OP_R      = 7'b0110011;
    localparam opcode_t OP_IMM    = 7'b0010011;
    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;
    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_AUIPC  = 7'b0010111;
    localparam opcode_t OP_SYSTEM = 7'b1110011;

    localparam funct3_t F3_BEQ  = 3'b000;
    localparam funct3_t F3_BNE  = 3'b001;
    localparam funct3_t F3_BLT  = 3'b100;
    localparam funct3_t F3_BGE  = 3'b101;
    localparam funct3_t F3_BLTU = 3'b110;
    localparam funct3_t F3_BGEU = 3'b111;

    // Result of classifying one instruction in DECODE.
    typedef struct packed {
        logic   illegal;   // unknown opcode or reserved branch funct3
        logic   system;    // ECALL/EBREAK: clean halt
        class_t cls;
    } decode_t;

    function automatic decode_t classify(input opcode_t op, input funct3_t f3);
        decode_t d;
        d.illegal = 1'b0;
        d.system  = 1'b0;
        d.cls     = C_R;
        case (op)
            OP_R:      d.cls = C_R;
            OP_IMM:    d.cls = C_IMM;
            OP_LOAD:   d.cls = C_LOAD;
            OP_STORE:  d.cls = C_STORE;
            OP_BRANCH: begin
                d.cls = C_BRANCH;
                // funct3 010/011 are reserved in the branch space
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    d.illegal = 1'b1;
                end
            end
            OP_JAL:    d.cls = C_JAL;
            OP_JALR:   d.cls = C_JALR;
            OP_LUI:    d.cls = C_LUI;
            OP_AUIPC:  d.cls = C_AUIPC;
            OP_SYSTEM: d.system = 1'b1;
            default:   d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    // Classes that write rd in WB (everything except STORE and BRANCH).
    function automatic logic writes_rd(input class_t c);
        return !(c == C_STORE || c == C_BRANCH);
    endfunction

endpackage

// File: rtl/core_ctrl_fsm_if.sv
// core_ctrl_fsm_if
//   Bundles the control FSM's datapath, memory-handshake and strobe signals.
//   master: the FSM (reads IR fields, flags and acks; drives requests/strobes).
//   slave : the datapath / memory side.
//   Signals: opcode, funct3, br_eq, br_lt, br_ltu, imem_req/imem_ack,
//            dmem_req/dmem_we/dmem_ack, ir_write, reg_write, pc_write,
//            isBranch, isJump, isJALR, halted, illegal.
interface core_ctrl_fsm_if;
    import core_ctrl_pkg::*;

    opcode_t opcode;
    funct3_t funct3;
    logic    br_eq;
    logic    br_lt;
    logic    br_ltu;
    logic    imem_req;
    logic    imem_ack;
    logic    dmem_req;
    logic    dmem_we;
    logic    dmem_ack;
    logic    ir_write;
    logic    reg_write;
    logic    pc_write;
    logic    isBranch;
    logic    isJump;
    logic    isJALR;
    logic    halted;
    logic    illegal;

    modport master (
        input  opcode, funct3, br_eq, br_lt, br_ltu, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_write, reg_write, pc_write,
               isBranch, isJump, isJALR, halted, illegal
    );

    modport slave (
        output opcode, funct3, br_eq, br_lt, br_ltu, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_write, reg_write, pc_write,
               isBranch, isJump, isJALR, halted, illegal
    );

endinterface

// File: rtl/core_ctrl_fsm_branch_resolve.sv
// branch_resolve
//   Combinational branch-direction decision from funct3 and comparator flags.
//   Ports: funct3_i (3), br_eq_i, br_lt_i (signed), br_ltu_i (unsigned) in;
//          taken_o out. Reserved funct3 codes resolve to not-taken (they
//          never reach WB because DECODE halts on them).
module branch_resolve
    import core_ctrl_pkg::*;
(
    input  funct3_t funct3_i,
    input  logic    br_eq_i,
    input  logic    br_lt_i,
    input  logic    br_ltu_i,
    output logic    taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o =  br_eq_i;
            F3_BNE:  taken_o = ~br_eq_i;
            F3_BLT:  taken_o =  br_lt_i;
            F3_BGE:  taken_o = ~br_lt_i;
            F3_BLTU: taken_o =  br_ltu_i;
            F3_BGEU: taken_o = ~br_ltu_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm
//   Multicycle control FSM for the RV32I core: FETCH -> DECODE -> EXEC ->
//   (MEM) -> WB per instruction, halting on ECALL/EBREAK or an illegal
//   encoding.
//   Ports: clk, rst (asynchronous, active-high);
//          bus (core_ctrl_fsm_if.master) carrying IR fields, branch flags,
//          imem/dmem handshakes and the PC/IR/regfile strobes.
//   Optional feature macro: CORE_CTRL_PERF_EN adds cycle_count (cycles out
//   of reset, HALT included) and instret_count (retired instructions), both
//   32-bit wrapping counters cleared by rst.
//   All outputs are decoded combinationally from the state/class registers,
//   so strobes appear in the same cycle the FSM is in the relevant state.
module core_ctrl_fsm
    import core_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    core_ctrl_fsm_if.master   bus
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [31:0]       cycle_count,
    output logic [31:0]       instret_count
`endif
);

    state_t  state_q,   state_d;
    class_t  class_q,   class_d;
    logic    halted_q,  halted_d;
    logic    illegal_q, illegal_d;

    logic    taken;
    decode_t dec;

    logic imem_req_c, dmem_req_c, dmem_we_c, ir_write_c;
    logic reg_write_c, pc_write_c, is_branch_c, is_jump_c, is_jalr_c;

    branch_resolve u_branch_resolve (
        .funct3_i (bus.funct3),
        .br_eq_i  (bus.br_eq),
        .br_lt_i  (bus.br_lt),
        .br_ltu_i (bus.br_ltu),
        .taken_o  (taken)
    );

    assign dec = classify(bus.opcode, bus.funct3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            class_q   <= C_R;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        pc_write_c  = 1'b0;
        is_branch_c = 1'b0;
        is_jump_c   = 1'b0;
        is_jalr_c   = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                class_d = dec.cls;
                if (dec.illegal) begin
                    state_d   = HALT;
                    halted_d  = 1'b1;
                    illegal_d = 1'b1;
                end else if (dec.system) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (class_q == C_LOAD || class_q == C_STORE) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (class_q == C_STORE);
                if (bus.dmem_ack) begin
                    state_d = WB;
                end
            end
            WB: begin
                pc_write_c  = 1'b1;
                reg_write_c = writes_rd(class_q);
                is_jump_c   = (class_q == C_JAL);
                is_jalr_c   = (class_q == C_JALR);
                // Comparator flags are taken live in WB, not latched earlier.
                is_branch_c = (class_q == C_BRANCH) && taken;
                state_d     = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                // Unreachable encodings park the core rather than guess.
                state_d  = HALT;
                halted_d = 1'b1;
            end
        endcase
    end

    // Reset leaves state at FETCH, so the request (and an ack arriving during
    // reset) must be masked by rst directly to keep every output low.
    assign bus.imem_req  = imem_req_c  & ~rst;
    assign bus.ir_write  = ir_write_c  & ~rst;
    assign bus.dmem_req  = dmem_req_c  & ~rst;
    assign bus.dmem_we   = dmem_we_c   & ~rst;
    assign bus.reg_write = reg_write_c & ~rst;
    assign bus.pc_write  = pc_write_c  & ~rst;
    assign bus.isBranch  = is_branch_c & ~rst;
    assign bus.isJump    = is_jump_c   & ~rst;
    assign bus.isJALR    = is_jalr_c   & ~rst;
    assign bus.halted    = halted_q;
    assign bus.illegal   = illegal_q;

`ifdef CORE_CTRL_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (pc_write_c) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`endif

endmodule
